// File: rtl/au_pkg.sv
// Shared helpers and mode constants for the leading-zero / normalise path.
package au_pkg;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  localparam int   WIDTH_DEF   = 8;
  localparam int   CW          = clog2(WIDTH_DEF + 1);
  localparam logic AU_LZ_PLAIN = 1'b0;
  localparam logic AU_LZ_SIGN  = 1'b1;

endpackage

// File: rtl/au_lead_zero_cnt.sv
// Combinational leading-zero / redundant-sign-bit detector.
// ARCH: 0 = linear scan, 1 = log tree, 2 = one-hot priority; results are identical.
module au_lead_zero_cnt import au_pkg::*; #(
  parameter int  WIDTH = 8,
  parameter int  ARCH  = 0,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic             sgn,
  output logic [WIDTH-1:0] z,
  output logic [CNT_W-1:0] cnt,
  output logic             no_det
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] hot;
  logic [CNT_W-1:0] lz;

  // Sign mode becomes a plain count over the bits that differ from the sign bit.
  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    d = a;
    if (sgn == AU_LZ_SIGN) d = {1'b0, a[WIDTH-2:0] ^ {(WIDTH-1){a[WIDTH-1]}}};
  end

  if (ARCH == 0) begin : g_linear
    always_comb begin
      lz  = CNT_W'(WIDTH);
      hot = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (d[i]) begin
          lz     = CNT_W'(WIDTH - 1 - i);
          hot    = '0;
          hot[i] = 1'b1;
        end
      end
    end
  end else if (ARCH == 1) begin : g_tree
    localparam int LB = clog2(WIDTH);
    localparam int P  = 1 << LB;
    always_comb begin
      logic [P-1:0]     v;
      logic [CNT_W-1:0] acc;
      v   = P'(d) << (P - WIDTH);
      acc = '0;
      for (int b = LB - 1; b >= 0; b--) begin
        if ((v >> (P - (1 << b))) == '0) begin
          acc = acc + CNT_W'(1 << b);
          v   = v << (1 << b);
        end
      end
      if (d == '0) begin
        lz  = CNT_W'(WIDTH);
        hot = '0;
      end else begin
        lz  = acc;
        hot = {1'b1, {(WIDTH-1){1'b0}}} >> acc;
      end
    end
  end else begin : g_onehot
    always_comb begin
      logic [WIDTH-1:0] s;
      s = d;
      for (int k = 1; k < WIDTH; k = k * 2) s = s | (s >> k);
      hot = s & ~(s >> 1);
      lz  = (d == '0) ? CNT_W'(WIDTH) : '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (hot[i]) lz = lz | CNT_W'(WIDTH - 1 - i);
      end
    end
  end

  always_comb begin
    z      = hot;
    cnt    = lz;
    no_det = (d == '0);
    if (sgn == AU_LZ_SIGN) begin
      cnt = lz - CNT_W'(1);
      z   = (d == '0) ? WIDTH'(1) : (hot << 1);
    end
  end

endmodule

// File: rtl/au_lead_zero_norm_pipe.sv
// Two-stage leading-zero / redundant-sign detector with a normalising barrel shifter.
// S1 holds the word and its detect fields; S2 adds the shifted word.
module au_lead_zero_norm_pipe import au_pkg::*; #(
  parameter int  WIDTH = 8,
  parameter int  ARCH  = 0,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] norm,
  output logic             no_det
);

  if (WIDTH < 2 || ARCH < 0 || ARCH > 2) begin : g_bad_param
    $fatal(1, "au_lead_zero_norm_pipe: illegal WIDTH=%0d or ARCH=%0d", WIDTH, ARCH);
  end

  logic             s1_v, s1_nd, s2_v, s2_nd;
  logic [WIDTH-1:0] s1_a, s1_z, s2_z, s2_norm;
  logic [CNT_W-1:0] s1_cnt, s2_cnt;
  logic [WIDTH-1:0] det_z, shifted;
  logic [CNT_W-1:0] det_cnt;
  logic             det_nd;
  logic             s1_load, s2_load;

  au_lead_zero_cnt #(.WIDTH(WIDTH), .ARCH(ARCH)) u_cnt (
    .a     (a),
    .sgn   (sgn),
    .z     (det_z),
    .cnt   (det_cnt),
    .no_det(det_nd)
  );

  // A stage loads when empty or when its current word leaves this cycle.
  assign s2_load  = ~s2_v | out_ready;
  assign s1_load  = ~s1_v | s2_load;
  assign in_ready = s1_load;

  // One mux level per count bit; shifts of WIDTH or more clear the word.
  always_comb begin
    shifted = s1_a;
    for (int k = 0; k < CNT_W; k++) begin
      if (s1_cnt[k]) shifted = shifted << (1 << k);
    end
  end

  // NOTE: registers use non-blocking '<=' so every stage samples pre-edge values.
  // NOTE: data registers are reset as well so the outputs read zero, not X, after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_z   <= '0;
      s1_cnt <= '0;
      s1_nd  <= 1'b0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_z   <= det_z;
        s1_cnt <= det_cnt;
        s1_nd  <= det_nd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_z    <= '0;
      s2_cnt  <= '0;
      s2_norm <= '0;
      s2_nd   <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_z    <= s1_z;
        s2_cnt  <= s1_cnt;
        s2_norm <= shifted;
        s2_nd   <= s1_nd;
      end
    end
  end

  assign out_valid = s2_v;
  assign z         = s2_z;
  assign cnt       = s2_cnt;
  assign norm      = s2_norm;
  assign no_det    = s2_nd;

endmodule

// File: tb/tb_au_lead_zero_norm_pipe.sv
// Scoreboard bench: directed checks on a WIDTH=8 instance, then randomized traffic
// on several WIDTH/ARCH configurations against a loop-based reference model.
module tb_au_lead_zero_norm_pipe;
  import au_pkg::*;

  localparam int W     = 8;
  localparam int MC    = clog2(W + 1);
  localparam int NCFG  = 5;
  localparam int CFG_W [NCFG] = '{8, 8, 8, 2, 33};
  localparam int CFG_A [NCFG] = '{0, 1, 2, 1, 2};
  localparam int WORDS = 2000;

  typedef struct {
    logic [63:0] z;
    int          cnt;
    logic [63:0] norm;
    bit          nd;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  bit go_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: scan from the top for the qualifying bit, then shift.
  function automatic res_t model(input int w, input logic [63:0] a, input bit s);
    res_t r;
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    r.nd = 1'b1;
    if (!s) begin
      r.z = '0;
      r.cnt = w;
      for (int i = w - 1; i >= 0; i--)
        if (a[i]) begin r.z = 64'd1 << i; r.cnt = w - 1 - i; r.nd = 1'b0; break; end
    end else begin
      r.z = 64'd1;
      r.cnt = w - 1;
      for (int i = w - 2; i >= 0; i--)
        if (a[i] != a[w-1]) begin r.z = 64'd1 << (i + 1); r.cnt = w - 2 - i; r.nd = 1'b0; break; end
    end
    r.norm = (a << r.cnt) & mask;
    return r;
  endfunction

  task automatic cmp(input string tag, input res_t e, input logic [63:0] z,
                     input int c, input logic [63:0] n, input bit nd);
    check({tag, "_z"}, z, e.z);
    check({tag, "_cnt"}, 64'(c), 64'(e.cnt));
    check({tag, "_norm"}, n, e.norm);
    check({tag, "_no_det"}, 64'(nd), 64'(e.nd));
  endtask

  // ---------------- directed instance ----------------
  logic          m_in_valid = 1'b0, m_in_ready, m_sgn = 1'b0;
  logic          m_out_valid, m_out_ready = 1'b1, m_no_det;
  logic [W-1:0]  m_a = '0, m_z, m_norm;
  logic [MC-1:0] m_cnt;
  res_t          m_q[$];

  au_lead_zero_norm_pipe #(.WIDTH(W), .ARCH(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .sgn(m_sgn), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .z(m_z), .cnt(m_cnt), .norm(m_norm), .no_det(m_no_det)
  );

  always @(negedge clk) begin
    res_t e;
    if (rst_n && m_out_valid && m_out_ready) begin
      if (m_q.size() == 0) check("m_spurious_out", 64'd1, 64'd0);
      else begin
        e = m_q.pop_front();
        cmp("m", e, 64'(m_z), int'(m_cnt), 64'(m_norm), m_no_det);
      end
    end
  end

  task automatic m_send(input logic [W-1:0] a, input bit s, output int waited);
    bit ok = 1'b0;
    waited = 0;
    m_in_valid = 1'b1; m_a = a; m_sgn = s;
    while (!ok && waited <= 100) begin
      @(negedge clk);
      if (m_in_ready) ok = 1'b1;
      else waited++;
    end
    if (ok) m_q.push_back(model(W, 64'(a), s));
    else check("m_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
  endtask

  task automatic m_drain(input string tag);
    int t = 0;
    while ((m_q.size() != 0 || m_out_valid) && t < 50) begin @(negedge clk); t++; end
    check(tag, 64'(m_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_expect(input logic [W-1:0] a, input bit s, input logic [W-1:0] ez,
                             input int ec, input logic [W-1:0] en, input bit end_);
    int w;
    string tag = $sformatf("dir_%0d_%02h", s, a);
    m_send(a, s, w);
    check({tag, "_lat1_valid"}, 64'(m_out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_lat2_valid"}, 64'(m_out_valid), 64'd1);
    check({tag, "_z"}, 64'(m_z), 64'(ez));
    check({tag, "_cnt"}, 64'(m_cnt), 64'(ec));
    check({tag, "_norm"}, 64'(m_norm), 64'(en));
    check({tag, "_no_det"}, 64'(m_no_det), 64'(end_));
    m_drain({tag, "_drain"});
  endtask

  initial begin
    int w, idx, t;
    bit have_snap, acc;
    logic [W-1:0] sz, sn;
    logic [MC-1:0] sc;
    logic [W-1:0] w4 [4] = '{8'h13, 8'hF3, 8'h01, 8'h2A};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid_low", 64'(m_out_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(m_in_ready), 64'd1);
    check("rst_out_valid", 64'(m_out_valid), 64'd0);
    check("rst_fields", 64'({m_z, m_cnt, m_norm, m_no_det}), 64'd0);

    send_expect(8'h13, AU_LZ_PLAIN, 8'h10, 3, 8'h98, 1'b0);
    send_expect(8'h00, AU_LZ_PLAIN, 8'h00, 8, 8'h00, 1'b1);
    send_expect(8'hF3, AU_LZ_SIGN,  8'h10, 3, 8'h98, 1'b0);
    send_expect(8'hFF, AU_LZ_SIGN,  8'h01, 7, 8'h80, 1'b1);
    send_expect(8'h00, AU_LZ_SIGN,  8'h01, 7, 8'h00, 1'b1);

    // Back-to-back walking one: one word per cycle, no wait states.
    for (int k = 0; k < 8; k++) begin
      m_send(8'h80 >> k, AU_LZ_PLAIN, w);
      check($sformatf("b2b_wait_%0d", k), 64'(w), 64'd0);
    end
    @(posedge clk);
    @(negedge clk); #1;
    check("b2b_throughput", 64'(m_q.size()), 64'd0);
    m_drain("b2b_drain");

    // Downstream stall: two words fill the pipe, outputs stay frozen.
    m_out_ready = 1'b0;
    idx = 0; have_snap = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) begin m_in_valid = 1'b1; m_a = w4[idx]; m_sgn = idx[0]; end
      @(negedge clk);
      if (m_out_valid) begin
        if (have_snap) begin
          check("stall_frozen_z", 64'(m_z), 64'(sz));
          check("stall_frozen_cnt", 64'(m_cnt), 64'(sc));
          check("stall_frozen_norm", 64'(m_norm), 64'(sn));
        end else begin
          have_snap = 1'b1; sz = m_z; sc = m_cnt; sn = m_norm;
        end
      end
      acc = m_in_valid && m_in_ready;
      if (acc) begin m_q.push_back(model(W, 64'(m_a), m_sgn)); idx++; end
      @(posedge clk); #1;
      m_in_valid = 1'b0;
    end
    check("stall_accepted", 64'(idx), 64'd2);
    check("stall_in_ready", 64'(m_in_ready), 64'd0);
    check("stall_out_valid", 64'(m_out_valid), 64'd1);
    m_out_ready = 1'b1;
    t = 0;
    while (idx < 4 && t < 20) begin
      m_in_valid = 1'b1; m_a = w4[idx]; m_sgn = idx[0];
      @(negedge clk);
      if (m_in_ready) begin m_q.push_back(model(W, 64'(m_a), m_sgn)); idx++; end
      @(posedge clk); #1;
      m_in_valid = 1'b0;
      t++;
    end
    check("stall_all_sent", 64'(idx), 64'd4);
    m_drain("stall_drain");

    // Reset with two words in flight.
    m_out_ready = 1'b0;
    m_send(8'h13, AU_LZ_PLAIN, w);
    m_send(8'hF3, AU_LZ_SIGN, w);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(m_out_valid), 64'd0);
    check("midrst_cnt", 64'(m_cnt), 64'd0);
    m_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 64'(m_in_ready), 64'd1);
    check("midrst_no_replay", 64'(m_out_valid), 64'd0);
    m_out_ready = 1'b1;
    send_expect(8'h13, AU_LZ_PLAIN, 8'h10, 3, 8'h98, 1'b0);

    go_rand = 1'b1;
    t = 0;
    while (n_done < NCFG && t < 60000) begin @(posedge clk); t++; end
    check("rand_all_done", 64'(n_done), 64'(NCFG));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- randomized instances ----------------
  for (genvar g = 0; g < NCFG; g++) begin : g_rand
    localparam int RW = CFG_W[g];
    localparam int RC = clog2(RW + 1);

    logic          iv = 1'b0, ir, sg = 1'b0, ov, ordy = 1'b1, nd;
    logic [RW-1:0] a = '0, z, nrm, pz, pn;
    logic [RC-1:0] c;
    bit            stalled = 1'b0;
    res_t          q[$];
    string         tag = $sformatf("r%0d_w%0d", g, RW);

    au_lead_zero_norm_pipe #(.WIDTH(RW), .ARCH(CFG_A[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .a(a), .sgn(sg), .out_valid(ov), .out_ready(ordy),
      .z(z), .cnt(c), .norm(nrm), .no_det(nd)
    );

    function automatic logic [RW-1:0] rand_word();
      logic [63:0] r = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: r = '0;
        1: r = '1;
        2: r = r >> (64 - RW + $urandom_range(0, RW));
        3: r = ~(r >> (64 - RW + $urandom_range(0, RW)));
        default: ;
      endcase
      return RW'(r);
    endfunction

    initial begin
      int sent = 0;
      int t = 0;
      bit acc;
      wait (go_rand);
      @(posedge clk); #1;
      while (sent < WORDS) begin
        if (!iv && $urandom_range(0, 3) != 0) begin
          iv = 1'b1; a = rand_word(); sg = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        acc = iv && ir;
        if (acc) begin q.push_back(model(RW, 64'(a), sg)); sent++; end
        @(posedge clk); #1;
        if (acc) iv = 1'b0;
      end
      while (q.size() != 0 && t < 1000) begin @(posedge clk); t++; end
      check({tag, "_drain"}, 64'(q.size()), 64'd0);
      n_done++;
    end

    initial begin
      wait (go_rand);
      forever begin
        @(posedge clk); #1;
        ordy = ($urandom_range(0, 3) != 0);
      end
    end

    always @(negedge clk) begin
      res_t e;
      if (!rst_n) stalled = 1'b0;
      else begin
        if (stalled) begin
          check({tag, "_hold_valid"}, 64'(ov), 64'd1);
          check({tag, "_hold_z"}, 64'(z), 64'(pz));
          check({tag, "_hold_norm"}, 64'(nrm), 64'(pn));
        end
        if (ov && ordy) begin
          if (q.size() == 0) check({tag, "_spurious_out"}, 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            cmp(tag, e, 64'(z), int'(c), 64'(nrm), nd);
          end
        end
        stalled = ov && !ordy;
        pz = z;
        pn = nrm;
      end
    end
  end

endmodule
